// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Input conditioning for the DE2-115 multiplier front panel. Raw active-low
// push-buttons and slider switches are brought into the Clk domain and cleaned
// up before they reach the multiplier datapath/control:
//   - every button and switch bit goes through a 2-flop synchronizer;
//   - each button is debounced independently; a level change is accepted only
//     after DEBOUNCE_CYCLES consecutive synchronized cycles that disagree with
//     the current debounced level;
//   - Press pulses for one cycle when a debounced press is accepted (this is
//     what drives Run and ClearA_LoadB); releases never pulse.
// The board Reset button is not conditioned here; it is this block's reset.
//
// Optional feature (compile-time macro BUTTON_CONDITIONER_AUTO_REPEAT_EN):
//   while a button stays held, extra Press pulses are issued REPEAT_DELAY
//   cycles after the initial press and then every REPEAT_CYCLES cycles.
//   Without the macro the repeat logic is not built and REPEAT_* are unused
//   apart from the elaboration sanity check.
//
// Ports
//   Clk     in   1         system clock (50 MHz on the board)
//   Reset   in   1         asynchronous, active-low reset
//   Btn_n   in   N_BTN     raw push-buttons, active-low, asynchronous to Clk
//   S_raw   in   SW_WIDTH  raw slider switches, asynchronous to Clk
//   Press   out  N_BTN     one-cycle pulse per accepted press (active-high)
//   Held    out  N_BTN     debounced pressed level (active-high)
//   S_sync  out  SW_WIDTH  2-flop-synchronized switches (no debounce)
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int N_BTN           = 3,
    parameter int SW_WIDTH        = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [N_BTN-1:0]    Btn_n,
    input  logic [SW_WIDTH-1:0] S_raw,
    output logic [N_BTN-1:0]    Press,
    output logic [N_BTN-1:0]    Held,
    output logic [SW_WIDTH-1:0] S_sync
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // The debounce counter cannot hold a terminal value below 1, and the
    // repeat intervals must be at least one cycle long.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("button_conditioner: DEBOUNCE_CYCLES must be >= 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("button_conditioner: REPEAT_DELAY and REPEAT_CYCLES must be >= 1");
    end

    // Synchronizers. Button flops reset to 1 (released), switch flops to 0.
    logic [N_BTN-1:0]    btn_s1_q, btn_s2_q;
    logic [SW_WIDTH-1:0] sw_s1_q,  sw_s2_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            btn_s1_q <= '1;
            btn_s2_q <= '1;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
        end else begin
            btn_s1_q <= Btn_n;
            btn_s2_q <= btn_s1_q;
            sw_s1_q  <= S_raw;
            sw_s2_q  <= sw_s1_q;
        end
    end

    // Debounce state.
    logic [N_BTN-1:0] held_q,  held_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] rise;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];

    // The counter only runs while the synchronized level disagrees with the
    // debounced level; any agreeing cycle (a bounce) drops it back to zero.
    // It is cleared on acceptance, so it never needs to wrap.
    always_comb begin
        held_d = held_q;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (~btn_s2_q[i] != held_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    held_d[i] = ~btn_s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise = held_d & ~held_q;

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_LAST_DLY = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_LAST_CYC = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt_q [N_BTN];
    logic [REP_W-1:0] rep_cnt_d [N_BTN];
    // rep_phase: 0 while waiting for the first repeat, 1 for periodic repeats.
    logic [N_BTN-1:0] rep_phase_q, rep_phase_d;
    logic [N_BTN-1:0] rep_fire;

    // Counting starts the cycle after the initial press. A release (held
    // falling this cycle) suppresses any repeat due in the same cycle.
    always_comb begin
        rep_phase_d = rep_phase_q;
        rep_fire    = '0;
        for (int i = 0; i < N_BTN; i++) begin
            rep_cnt_d[i] = '0;
            if (!held_q[i] || !held_d[i]) begin
                rep_phase_d[i] = 1'b0;
            end else if (rep_cnt_q[i] == (rep_phase_q[i] ? REP_LAST_CYC : REP_LAST_DLY)) begin
                rep_fire[i]    = 1'b1;
                rep_phase_d[i] = 1'b1;
            end else begin
                rep_cnt_d[i] = rep_cnt_q[i] + REP_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rep_phase_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                rep_cnt_q[i] <= '0;
            end
        end else begin
            rep_phase_q <= rep_phase_d;
            for (int i = 0; i < N_BTN; i++) begin
                rep_cnt_q[i] <= rep_cnt_d[i];
            end
        end
    end

    assign press_d = rise | rep_fire;
`else
    assign press_d = rise;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            held_q  <= '0;
            press_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            held_q  <= held_d;
            press_q <= press_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign Press  = press_q;
    assign Held   = held_q;
    assign S_sync = sw_s2_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with small debounce/repeat parameters.
// The reference model works from the recorded history of Btn_n/S_raw values
// seen at each clock edge: a debounced level flips once the synchronized
// input has disagreed with it for D consecutive edges since the last flip.
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RC = 3;
    localparam int HN = 8192;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [2:0] Btn_n = 3'b111;
    logic [7:0] S_raw = 8'h00;
    logic [2:0] Press, Held;
    logic [7:0] S_sync;

    button_conditioner #(
        .N_BTN(3), .SW_WIDTH(8), .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD), .REPEAT_CYCLES(RC)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Btn_n(Btn_n), .S_raw(S_raw),
        .Press(Press), .Held(Held), .S_sync(S_sync)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [2:0] rawh [HN];
    logic [7:0] swh  [HN];
    int         e = 0;
    int         hist_start = 0;
    int         last_flip [3];
    int         next_rep  [3];
    logic [2:0] held_m  = '0;
    logic [2:0] press_m = '0;
    logic [7:0] s_m     = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, e);
        end
    endtask

    // Pressed state (active-high) as the debouncer sees it at edge w:
    // the raw value sampled two edges earlier, released before history starts.
    function automatic logic [2:0] pressed(input int w);
        if (w - 2 < hist_start) return 3'b000;
        return ~rawh[w-2];
    endfunction

    function automatic void model_edge();
        for (int i = 0; i < 3; i++) begin
            bit flip;
            flip = (last_flip[i] <= e - D);
            for (int w = e - D + 1; w <= e; w++) begin
                logic [2:0] pw;
                pw = pressed(w);
                if (pw[i] == held_m[i]) flip = 0;
            end
            press_m[i] = 1'b0;
            if (flip) begin
                held_m[i]    = ~held_m[i];
                last_flip[i] = e;
                if (held_m[i]) begin
                    press_m[i]  = 1'b1;
                    next_rep[i] = e + RD;
                end
            end
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
            else if (held_m[i] && e == next_rep[i]) begin
                press_m[i]  = 1'b1;
                next_rep[i] = e + RC;
            end
`endif
        end
        s_m = (e - 1 >= hist_start) ? swh[e-1] : 8'h00;
    endfunction

    // One clock: record inputs at the edge, advance the model, check #1 later.
    task automatic step();
        @(posedge Clk);
        e++;
        rawh[e] = Btn_n;
        swh[e]  = S_raw;
        if (Reset) model_edge();
        #1;
        chk("press",  {29'd0, Press}, {29'd0, press_m});
        chk("held",   {29'd0, Held},  {29'd0, held_m});
        chk("s_sync", {24'd0, S_sync}, {24'd0, s_m});
    endtask

    // Assert reset between edges, check outputs clear before the next edge,
    // hold for n edges, then release just after an edge.
    task automatic do_reset(input int n);
        Reset   = 1'b0;
        held_m  = '0;
        press_m = '0;
        s_m     = '0;
        #1;
        chk("rst_press",  {29'd0, Press}, 32'd0);
        chk("rst_held",   {29'd0, Held},  32'd0);
        chk("rst_s_sync", {24'd0, S_sync}, 32'd0);
        repeat (n) step();
        Reset      = 1'b1;
        hist_start = e + 1;
        for (int i = 0; i < 3; i++) last_flip[i] = e;
    endtask

    int         k;
    int         first;
    int         cnt;
    logic [2:0] pv;

    initial begin
        for (int i = 0; i < 3; i++) begin
            last_flip[i] = 0;
            next_rep[i]  = 0;
        end
        #1;
        do_reset(3);
        repeat (4) step();

        // 1: single press held
        k = e; first = -1;
        Btn_n = 3'b110;
        repeat (10) begin
            step();
            if (Press[0] && first < 0) first = e;
        end
        chk("t1_press_edge", first - k, 6);
        Btn_n = 3'b111;
        repeat (8) step();

        // 2: bouncy press, count restarts
        k = e; first = -1; cnt = 0;
        Btn_n = 3'b110;
        repeat (3) begin step(); if (Press[0]) cnt++; end
        Btn_n = 3'b111;
        step(); if (Press[0]) cnt++;
        Btn_n = 3'b110;
        repeat (10) begin
            step();
            if (Press[0]) begin cnt++; if (first < 0) first = e; end
        end
        chk("t2_press_edge", first - k, 10);
        chk("t2_press_count", cnt, 1);

        // 3: bouncy release
        cnt = 0; first = -1;
        Btn_n = 3'b111; repeat (2) begin step(); if (Press[0]) cnt++; end
        Btn_n = 3'b110; step(); if (Press[0]) cnt++;
        Btn_n = 3'b111; k = e;
        repeat (10) begin
            step();
            if (Press[0]) cnt++;
            if (!Held[0] && first < 0) first = e;
        end
        chk("t3_release_edge", first - k, 6);
        chk("t3_no_press", cnt, 0);

        // 4: two buttons together
        k = e; first = -1; pv = '0;
        Btn_n = 3'b010;
        repeat (8) begin
            step();
            if (Press != 3'b000 && first < 0) begin first = e; pv = Press; end
        end
        chk("t4_press_edge", first - k, 6);
        chk("t4_press_val", {29'd0, pv}, 32'h5);
        Btn_n = 3'b111;
        repeat (8) step();

        // 5: reset while held, re-accept after release; switch sync
        Btn_n = 3'b101;
        repeat (8) step();
        chk("t5_held_before_rst", {29'd0, Held}, 32'h2);
        do_reset(2);
        k = e; first = -1;
        repeat (8) begin
            step();
            if (Press[1] && first < 0) first = e;
        end
        chk("t5_repress_edge", first - k, 6);
        S_raw = 8'hA5;
        step();
        step();
        chk("t5_s_sync", {24'd0, S_sync}, 32'hA5);
        Btn_n = 3'b111;
        repeat (8) step();

        // reset mid-count: no partial pulse afterwards
        Btn_n = 3'b110;
        repeat (4) step();
        do_reset(1);
        Btn_n = 3'b111;
        cnt = 0;
        repeat (8) begin step(); if (Press != 3'b000) cnt++; end
        chk("midcount_no_press", cnt, 0);

        // 6: long hold, repeat behaviour
        k = e; cnt = 0;
        Btn_n = 3'b110;
        repeat (22) begin step(); if (Press[0]) cnt++; end
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
        chk("t6_pulse_count", cnt, 4);
`else
        chk("t6_pulse_count", cnt, 1);
`endif
        Btn_n = 3'b111;
        repeat (10) step();

        // randomized bounce / hold / switch / reset traffic
        for (int it = 0; it < 250; it++) begin
            int hold;
            if ($urandom_range(0, 39) == 0) begin
                do_reset($urandom_range(1, 3));
            end
            if ($urandom_range(0, 2) != 0) Btn_n = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) S_raw = 8'($urandom);
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 12) : $urandom_range(1, 4);
            repeat (hold) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
